ultrasonic_link_ctrl: RTL

// Half-duplex link controller for ultrasonicModem300k on the 100 MHz clk domain.

---
 rtl/ultrasonic_link_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_link_ctrl.sv
// Half-duplex framing controller for the ultrasonic modem: timed TX bit stream,
// oversampled RX frame decoder, warm-up gating and echo blanking.
module ultrasonic_link_ctrl #(
  parameter int unsigned BIT_CYCLES    = 2000,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter int unsigned WARMUP_CYCLES = 5000,
  parameter int unsigned GUARD_CYCLES  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       busy,
  output logic       modem_enable,
  output logic       modem_data_in,
  input  logic       modem_data_out
);

  localparam int unsigned TimerMaxA = (WARMUP_CYCLES > GUARD_CYCLES) ? WARMUP_CYCLES
                                                                      : GUARD_CYCLES;
  localparam int unsigned TimerMax  = (TimerMaxA > BIT_CYCLES) ? TimerMaxA : BIT_CYCLES;
  localparam int unsigned TW        = $clog2(TimerMax);
  localparam int unsigned IdxMax    = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned IW        = $clog2(IdxMax);
  localparam int unsigned BW        = $clog2(BIT_CYCLES);
  localparam int unsigned RW        = $clog2(PREAMBLE_BITS + 10);

  localparam logic [TW-1:0] WarmupLast = TW'(WARMUP_CYCLES - 1);
  localparam logic [TW-1:0] GuardLast  = TW'(GUARD_CYCLES - 1);
  localparam logic [TW-1:0] BitLast    = TW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] PreLast    = IW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] RxBitLast  = BW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] RxHalf     = BW'(BIT_CYCLES / 2);
  localparam logic [RW-1:0] RxPreBits  = RW'(PREAMBLE_BITS);
  localparam logic [RW-1:0] RxStopIdx  = RW'(PREAMBLE_BITS + 9);

  localparam logic [2:0] StWarmup   = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StPreamble = 3'd2;
  localparam logic [2:0] StStart    = 3'd3;
  localparam logic [2:0] StData     = 3'd4;
  localparam logic [2:0] StStop     = 3'd5;
  localparam logic [2:0] StGuard    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [IW-1:0] tx_idx_q, tx_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          line_q, line_d;
  logic          enable_q;
  logic          sync1_q, sync2_q;
  logic          edge_q, edge_d;
  logic          rx_busy_q, rx_busy_d;
  logic [BW-1:0] rx_timer_q, rx_timer_d;
  logic [RW-1:0] rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;

  logic handshake;
  logic bit_end;
  logic fell;

  assign tx_ready  = (state_q == StIdle) && !rx_busy_q && !rst;
  assign handshake = tx_valid && tx_ready;
  assign bit_end   = (tx_timer_q == BitLast);
  assign fell      = edge_q && !sync2_q;

  always_comb begin
    state_d    = state_q;
    tx_timer_d = tx_timer_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    case (state_q)
      StWarmup: begin
        if (tx_timer_q == WarmupLast) begin
          state_d    = StIdle;
          tx_timer_d = '0;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      StIdle: begin
        if (handshake) begin
          state_d    = StPreamble;
          tx_timer_d = '0;
          tx_idx_d   = '0;
          tx_byte_d  = tx_data;
        end
      end
      StPreamble: begin
        if (bit_end) begin
          tx_timer_d = '0;
          if (tx_idx_q == PreLast) begin
            state_d  = StStart;
            tx_idx_d = '0;
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_timer_d = '0;
          tx_idx_d   = '0;
          state_d    = StData;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          tx_timer_d = '0;
          if (tx_idx_q == IW'(7)) begin
            state_d  = StStop;
            tx_idx_d = '0;
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          tx_timer_d = '0;
          state_d    = StGuard;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      StGuard: begin
        if (tx_timer_q == GuardLast) begin
          tx_timer_d = '0;
          state_d    = StIdle;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      default: begin
        state_d    = StWarmup;
        tx_timer_d = '0;
      end
    endcase
  end

  // Line level is derived from the next state so each bit starts on the transition edge.
  always_comb begin
    case (state_d)
      StPreamble: line_d = tx_idx_d[0];
      StStart:    line_d = 1'b0;
      StData:     line_d = tx_byte_d[tx_idx_d[2:0]];
      default:    line_d = 1'b1;
    endcase
  end

  always_comb begin
    edge_d     = sync2_q;
    rx_busy_d  = rx_busy_q;
    rx_timer_d = rx_timer_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (state_q != StIdle) begin
      // Blanks own echo: receiver held in hunt with a cleared edge detector.
      rx_busy_d = 1'b0;
      edge_d    = 1'b0;
    end else if (!rx_busy_q) begin
      if (fell && !handshake) begin
        rx_busy_d  = 1'b1;
        rx_timer_d = RxHalf;
        rx_idx_d   = '0;
      end
    end else if (rx_timer_q == RxBitLast) begin
      rx_timer_d = '0;
      rx_idx_d   = rx_idx_q + RW'(1);
      if (rx_idx_q < RxPreBits) begin
        if (sync2_q != rx_idx_q[0]) rx_busy_d = 1'b0;
      end else if (rx_idx_q == RxPreBits) begin
        if (sync2_q) rx_busy_d = 1'b0;
      end else if (rx_idx_q == RxStopIdx) begin
        rx_busy_d = 1'b0;
        if (sync2_q) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          rx_err_d = 1'b1;
        end
      end else begin
        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
      end
    end else begin
      rx_timer_d = rx_timer_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWarmup;
      tx_timer_q <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      line_q     <= 1'b1;
      enable_q   <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_q     <= 1'b0;
      rx_busy_q  <= 1'b0;
      rx_timer_q <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_timer_q <= tx_timer_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      line_q     <= line_d;
      enable_q   <= 1'b1;
      sync1_q    <= modem_data_out;
      sync2_q    <= sync1_q;
      edge_q     <= edge_d;
      rx_busy_q  <= rx_busy_d;
      rx_timer_q <= rx_timer_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_err_q;
  assign busy          = (state_q != StIdle) || rx_busy_q;
  assign modem_enable  = enable_q;
  assign modem_data_in = line_q;

endmodule
